// File: rtl/fifo_stim_gen.sv
// -----------------------------------------------------------------------------
// fifo_stim_gen
//
// Synthesizable traffic generator for the write/read side of a synchronous
// FIFO. A test controller starts a run with a pattern mode and an operation
// budget. The generator then issues registered wr_en / rd_en / data_in until
// that many active cycles (wr_en | rd_en) have gone out. It then pulses done.
//
// Pattern modes (latched at start):
//   0 random       : LFSR-driven enables with WR_PCT / RD_PCT probabilities,
//                    write data taken from the LFSR top bits
//   1 fill-drain   : FIFO_DEPTH writes, then FIFO_DEPTH reads, repeating
//   2 simultaneous : write and read every cycle
//   3 alternate    : write, read, write, read, ...
//   In modes 1-3 the write data is a counter starting at 0.
//
// Optional feature macro: FIFO_STIM_LEGAL_ONLY_EN
//   When it is defined, wr_en is masked by !full and rd_en by !empty. A masked
//   request is not counted and does not advance the fill-drain burst.
//   When it is undefined, full/empty are ignored and requests are issued raw.
//
// Ports:
//   clk       in   1           rising-edge clock
//   rst       in   1           asynchronous active-high reset
//   start     in   1           run request, sampled only while idle
//   mode      in   2           pattern mode, latched at start
//   num_ops   in   16          active-cycle budget, latched at start
//   full      in   1           FIFO full flag
//   empty     in   1           FIFO empty flag
//   wr_en     out  1           FIFO write enable (registered)
//   rd_en     out  1           FIFO read enable (registered)
//   data_in   out  FIFO_WIDTH  FIFO write data (registered, held between writes)
//   busy      out  1           high while running
//   done      out  1           one-cycle pulse after busy falls
//   op_count  out  16          active cycles issued in the current/last run
// -----------------------------------------------------------------------------
module fifo_stim_gen #(
    parameter int          FIFO_WIDTH = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          WR_PCT     = 70,
    parameter int          RD_PCT     = 30,
    parameter logic [31:0] SEED       = 32'hACE1_2024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [15:0]           num_ops,
    input  logic                  full,
    input  logic                  empty,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]  MODE_RANDOM = 2'd0;
    localparam logic [1:0]  MODE_FILL   = 2'd1;
    localparam logic [1:0]  MODE_SIMUL  = 2'd2;
    localparam logic [1:0]  MODE_ALT    = 2'd3;

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Thresholds live on a 9-bit scale so that 100% (256) beats every 8-bit
    // LFSR byte and 0% beats none. Out-of-range percentages are clamped.
    localparam int          WR_THR   = (WR_PCT >= 100) ? 256 : ((WR_PCT <= 0) ? 0 : (WR_PCT * 256) / 100);
    localparam int          RD_THR   = (RD_PCT >= 100) ? 256 : ((RD_PCT <= 0) ? 0 : (RD_PCT * 256) / 100);
    localparam logic [8:0]  WR_THR_V = 9'(WR_THR);
    localparam logic [8:0]  RD_THR_V = 9'(RD_THR);

    localparam int             BW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [BW-1:0]  BURST_LAST  = BW'(FIFO_DEPTH - 1);
    localparam logic [BW-1:0]  BURST_ONE   = BW'(1'b1);
    localparam logic [FIFO_WIDTH-1:0] DATA_ONE = FIFO_WIDTH'(1'b1);

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        logic [31:0] shifted;
        shifted = {1'b0, cur[31:1]};
        if (cur[0]) begin
            return shifted ^ LFSR_TAPS;
        end else begin
            return shifted;
        end
    endfunction

    // Registered state
    state_t                  state_r;
    logic [1:0]              mode_r;
    logic [15:0]             num_ops_r;
    logic [15:0]             op_count_r;
    logic [BW-1:0]           burst_r;
    logic                    phase_r;      // fill-drain: 0 = filling, 1 = draining
    logic                    alt_r;        // alternate: 0 = write slot, 1 = read slot
    logic [FIFO_WIDTH-1:0]   data_cnt_r;
    logic [31:0]             lfsr_r;
    logic                    wr_en_r;
    logic                    rd_en_r;
    logic [FIFO_WIDTH-1:0]   data_in_r;
    logic                    busy_r;
    logic                    done_r;

    // Next-state values
    state_t                  state_nxt_s;
    logic [1:0]              mode_nxt_s;
    logic [15:0]             num_ops_nxt_s;
    logic [15:0]             op_count_nxt_s;
    logic [BW-1:0]           burst_nxt_s;
    logic                    phase_nxt_s;
    logic                    alt_nxt_s;
    logic [FIFO_WIDTH-1:0]   data_cnt_nxt_s;
    logic [31:0]             lfsr_nxt_s;
    logic                    wr_en_nxt_s;
    logic                    rd_en_nxt_s;
    logic [FIFO_WIDTH-1:0]   data_in_nxt_s;
    logic                    busy_nxt_s;
    logic                    done_nxt_s;

    // Request decode and legality gating
    logic                    wr_req_s;
    logic                    rd_req_s;
    logic                    wr_ok_s;
    logic                    rd_ok_s;
    logic                    active_s;
    logic                    burst_step_s;
    logic [FIFO_WIDTH-1:0]   lfsr_data_s;

    // Random-mode write data: the top FIFO_WIDTH bits of the LFSR. Widths above
    // 32 bits wrap around the register instead of indexing past it.
    always_comb begin
        lfsr_data_s = '0;
        for (int i = 0; i < FIFO_WIDTH; i++) begin
            lfsr_data_s[i] = lfsr_r[(i + 64 - FIFO_WIDTH) % 32];
        end
    end

    // Raw write/read request for the current pattern.
    always_comb begin
        wr_req_s = 1'b0;
        rd_req_s = 1'b0;
        case (mode_r)
            MODE_RANDOM: begin
                wr_req_s = ({1'b0, lfsr_r[7:0]}  < WR_THR_V);
                rd_req_s = ({1'b0, lfsr_r[15:8]} < RD_THR_V);
            end
            MODE_FILL: begin
                wr_req_s = ~phase_r;
                rd_req_s = phase_r;
            end
            MODE_SIMUL: begin
                wr_req_s = 1'b1;
                rd_req_s = 1'b1;
            end
            MODE_ALT: begin
                wr_req_s = ~alt_r;
                rd_req_s = alt_r;
            end
            default: begin
                wr_req_s = 1'b0;
                rd_req_s = 1'b0;
            end
        endcase
    end

`ifdef FIFO_STIM_LEGAL_ONLY_EN
    // Mask requests the FIFO cannot accept. The flags are one cycle old, so one
    // over-issue is possible right at the boundary.
    always_comb begin
        wr_ok_s = wr_req_s & ~full;
        rd_ok_s = rd_req_s & ~empty;
    end
`else
    // Flags are ignored in this build, so overflow and underflow are exercised on purpose.
    logic unused_flags_s;
    assign unused_flags_s = full ^ empty;

    // Requests are issued as computed.
    always_comb begin
        wr_ok_s = wr_req_s;
        rd_ok_s = rd_req_s;
    end
`endif

    // Active-cycle and burst-advance qualifiers.
    always_comb begin
        active_s     = wr_ok_s | rd_ok_s;
        burst_step_s = phase_r ? rd_ok_s : wr_ok_s;
    end

    // FSM next-state and next-output computation.
    always_comb begin
        state_nxt_s    = state_r;
        mode_nxt_s     = mode_r;
        num_ops_nxt_s  = num_ops_r;
        op_count_nxt_s = op_count_r;
        burst_nxt_s    = burst_r;
        phase_nxt_s    = phase_r;
        alt_nxt_s      = alt_r;
        data_cnt_nxt_s = data_cnt_r;
        lfsr_nxt_s     = lfsr_r;
        wr_en_nxt_s    = 1'b0;
        rd_en_nxt_s    = 1'b0;
        data_in_nxt_s  = data_in_r;
        busy_nxt_s     = 1'b0;
        done_nxt_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s    = ST_RUN;
                    mode_nxt_s     = mode;
                    num_ops_nxt_s  = num_ops;
                    op_count_nxt_s = 16'd0;
                    burst_nxt_s    = '0;
                    phase_nxt_s    = 1'b0;
                    alt_nxt_s      = 1'b0;
                    data_cnt_nxt_s = '0;
                    busy_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end

            ST_RUN: begin
                lfsr_nxt_s = lfsr_next(lfsr_r);
                // op_count counts enables already registered. Once the budget
                // is met, the enables drop while done rises. This keeps done
                // from ever sharing a cycle with an active enable.
                if (op_count_r == num_ops_r) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    busy_nxt_s  = 1'b1;
                    wr_en_nxt_s = wr_ok_s;
                    rd_en_nxt_s = rd_ok_s;
                    alt_nxt_s   = ~alt_r;

                    if (active_s) begin
                        op_count_nxt_s = op_count_r + 16'd1;
                    end else begin
                        op_count_nxt_s = op_count_r;
                    end

                    if (wr_ok_s) begin
                        if (mode_r == MODE_RANDOM) begin
                            data_in_nxt_s = lfsr_data_s;
                        end else begin
                            data_in_nxt_s  = data_cnt_r;
                            data_cnt_nxt_s = data_cnt_r + DATA_ONE;
                        end
                    end else begin
                        data_in_nxt_s = data_in_r;
                    end

                    if ((mode_r == MODE_FILL) && burst_step_s) begin
                        if (burst_r == BURST_LAST) begin
                            burst_nxt_s = '0;
                            phase_nxt_s = ~phase_r;
                        end else begin
                            burst_nxt_s = burst_r + BURST_ONE;
                        end
                    end else begin
                        burst_nxt_s = burst_r;
                    end
                end
            end

            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            mode_r     <= 2'd0;
            num_ops_r  <= 16'd0;
            op_count_r <= 16'd0;
            burst_r    <= '0;
            phase_r    <= 1'b0;
            alt_r      <= 1'b0;
            data_cnt_r <= '0;
            lfsr_r     <= SEED_EFF;
            wr_en_r    <= 1'b0;
            rd_en_r    <= 1'b0;
            data_in_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mode_r     <= mode_nxt_s;
            num_ops_r  <= num_ops_nxt_s;
            op_count_r <= op_count_nxt_s;
            burst_r    <= burst_nxt_s;
            phase_r    <= phase_nxt_s;
            alt_r      <= alt_nxt_s;
            data_cnt_r <= data_cnt_nxt_s;
            lfsr_r     <= lfsr_nxt_s;
            wr_en_r    <= wr_en_nxt_s;
            rd_en_r    <= rd_en_nxt_s;
            data_in_r  <= data_in_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign wr_en    = wr_en_r;
    assign rd_en    = rd_en_r;
    assign data_in  = data_in_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign op_count = op_count_r;

endmodule

// File: tb/tb_fifo_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_fifo_stim_gen
//
// Directed bench for fifo_stim_gen. The DUT is built with WR_PCT=100 and
// RD_PCT=0, so random mode writes on every cycle and never reads. The write
// data then follows the LFSR sequence from SEED.
// -----------------------------------------------------------------------------
module tb_fifo_stim_gen;

    localparam int          W    = 16;
    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [15:0]   num_ops = 16'd0;
    logic          full = 1'b0;
    logic          empty = 1'b0;
    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  data_in;
    logic          busy;
    logic          done;
    logic [15:0]   op_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    fifo_stim_gen #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (8),
        .WR_PCT     (100),
        .RD_PCT     (0),
        .SEED       (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .num_ops  (num_ops),
        .full     (full),
        .empty    (empty),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_step(input logic [31:0] cur);
        logic [31:0] s;
        s = {1'b0, cur[31:1]};
        if (cur[0]) s = s ^ TAPS;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ew, input logic er,
                           input logic [W-1:0] ed, input logic eb, input logic edn,
                           input logic [15:0] eop);
        chk($sformatf("%s.wr_en", tag),    {31'd0, wr_en},    {31'd0, ew});
        chk($sformatf("%s.rd_en", tag),    {31'd0, rd_en},    {31'd0, er});
        chk($sformatf("%s.data_in", tag),  {16'd0, data_in},  {16'd0, ed});
        chk($sformatf("%s.busy", tag),     {31'd0, busy},     {31'd0, eb});
        chk($sformatf("%s.done", tag),     {31'd0, done},     {31'd0, edn});
        chk($sformatf("%s.op_count", tag), {16'd0, op_count}, {16'd0, eop});
    endtask

    task automatic do_start(input logic [1:0] m, input logic [15:0] n);
        start   = 1'b1;
        mode    = m;
        num_ops = n;
        tick();
        start   = 1'b0;
    endtask

    logic [31:0]  lfsr_m;
    logic         exp_rd;

    initial begin
        // ---- reset state ----
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0);
        #4 rst = 1'b0;
        tick();
        chk_out("idle", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0);

        // ---- mode 2, 5 ops ----
        do_start(2'd2, 16'd5);
        chk_out("m2.first", 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("m2.op%0d", i), 1'b1, 1'b1, 16'(i), 1'b1, 1'b0, 16'(i + 1));
        end
        tick();
        chk_out("m2.done", 1'b0, 1'b0, 16'd4, 1'b0, 1'b1, 16'd5);
        tick();
        chk_out("m2.after", 1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 16'd5);

        // ---- mode 1 fill-drain, 32 ops ----
        do_start(2'd1, 16'd32);
        chk_out("m1.first", 1'b0, 1'b0, 16'd4, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            case (i / 8)
                0: chk_out($sformatf("m1.op%0d", i), 1'b1, 1'b0, 16'(i),      1'b1, 1'b0, 16'(i + 1));
                1: chk_out($sformatf("m1.op%0d", i), 1'b0, 1'b1, 16'd7,       1'b1, 1'b0, 16'(i + 1));
                2: chk_out($sformatf("m1.op%0d", i), 1'b1, 1'b0, 16'(i - 8),  1'b1, 1'b0, 16'(i + 1));
                default: chk_out($sformatf("m1.op%0d", i), 1'b0, 1'b1, 16'd15, 1'b1, 1'b0, 16'(i + 1));
            endcase
        end
        tick();
        chk_out("m1.done", 1'b0, 1'b0, 16'd15, 1'b0, 1'b1, 16'd32);

        // ---- num_ops = 0 ----
        tick();
        do_start(2'd2, 16'd0);
        chk_out("z.busy", 1'b0, 1'b0, 16'd15, 1'b1, 1'b0, 16'd0);
        tick();
        chk_out("z.done", 1'b0, 1'b0, 16'd15, 1'b0, 1'b1, 16'd0);
        tick();
        chk_out("z.idle", 1'b0, 1'b0, 16'd15, 1'b0, 1'b0, 16'd0);

        // ---- mode 3 with an ignored start, then reset mid-run ----
        do_start(2'd3, 16'd10);
        chk_out("m3.first", 1'b0, 1'b0, 16'd15, 1'b1, 1'b0, 16'd0);
        tick();
        chk_out("m3.op0", 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 16'd1);
        start   = 1'b1;
        mode    = 2'd2;
        num_ops = 16'd3;
        tick();
        start   = 1'b0;
        chk_out("m3.op1", 1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 16'd2);
        tick();
        chk_out("m3.op2", 1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 16'd3);
        tick();
        chk_out("m3.op3", 1'b0, 1'b1, 16'd1, 1'b1, 1'b0, 16'd4);
        #2 rst = 1'b1;
        #1;
        chk_out("m3.rst", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0);
        #2 rst = 1'b0;
        tick();
        chk_out("m3.post0", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0);
        tick();
        chk_out("m3.post1", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0);

        // ---- mode 0 random (100% write, 0% read) from a fresh SEED ----
        lfsr_m = SEED;
        do_start(2'd0, 16'd10);
        chk_out("m0.first", 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_out($sformatf("m0.op%0d", i), 1'b1, 1'b0, lfsr_m[31:16], 1'b1, 1'b0, 16'(i + 1));
            lfsr_m = model_step(lfsr_m);
        end
        tick();
        chk_out("m0.done", 1'b0, 1'b0, 16'hC9B1 & 16'h0000 | data_in_exp_last(SEED), 1'b0, 1'b1, 16'd10);

        // ---- mode 2 with empty held high ----
`ifdef FIFO_STIM_LEGAL_ONLY_EN
        exp_rd = 1'b0;
`else
        exp_rd = 1'b1;
`endif
        tick();
        empty = 1'b1;
        do_start(2'd2, 16'd4);
        chk_out("emp.first", 1'b0, 1'b0, data_in_exp_last(SEED), 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("emp.op%0d", i), 1'b1, exp_rd, 16'(i), 1'b1, 1'b0, 16'(i + 1));
        end
        tick();
        chk_out("emp.done", 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 16'd4);
        empty = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Last write data of the 10-op random run: top half of the 10th LFSR state.
    function automatic logic [W-1:0] data_in_exp_last(input logic [31:0] seed);
        logic [31:0] s;
        s = seed;
        for (int k = 0; k < 9; k++) s = model_step(s);
        return s[31:16];
    endfunction

endmodule
